// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment scan driver.
// Segment vectors are active-high with bit order {g,f,e,d,c,b,a},
// so bit 0 is segment a and bit 6 is segment g.
package seg7_pkg;

  localparam int SCAN_DIV_DEF = 1000;

  localparam int SEG_BIT_A = 0;
  localparam int SEG_BIT_B = 1;
  localparam int SEG_BIT_C = 2;
  localparam int SEG_BIT_D = 3;
  localparam int SEG_BIT_E = 4;
  localparam int SEG_BIT_F = 5;
  localparam int SEG_BIT_G = 6;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Non-BCD codes (10..15) render as a dash so a corrupt digit is visible.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: digit load bus and display outputs of the scan driver.
//   master: drives en, load, digits, dp_in; observes an, seg, dp, frame
//   slave : the scan driver itself
interface seg7_scan_if #(
  parameter int NDIG = 4
) ();
  logic                en;
  logic                load;
  logic [4*NDIG-1:0]   digits;
  logic [NDIG-1:0]     dp_in;
  logic [NDIG-1:0]     an;
  logic [6:0]          seg;
  logic                dp;
  logic                frame;

  modport master (
    output en, load, digits, dp_in,
    input  an, seg, dp, frame
  );

  modport slave (
    input  en, load, digits, dp_in,
    output an, seg, dp, frame
  );
endinterface

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD to 7-segment decoder.
//   bcd_i [3:0] : digit value
//   seg_o [6:0] : active-high segments {g,f,e,d,c,b,a}; dash for 10..15
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = bcd_to_seg(bcd_i);
  end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed 7-segment display driver.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : seg7_scan_if.slave (en, load, digits, dp_in in; an, seg, dp, frame out)
// Digits are captured into shadow registers on load, then scanned one per
// SCAN_DIV cycles. All outputs are registered and held at output polarity.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int SCAN_DIV    = SCAN_DIV_DEF,
  parameter int BLANK_LZ    = 1,
  parameter int AN_ACT_LOW  = 1,
  parameter int SEG_ACT_LOW = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  seg7_scan_if.slave  bus
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NDIG);
  localparam logic [PW-1:0]   PRE_TC   = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(NDIG - 1);
  localparam logic [NDIG-1:0] AN_OFF   = (AN_ACT_LOW != 0) ? {NDIG{1'b1}} : {NDIG{1'b0}};
  localparam logic [6:0]      SEG_OFF  = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic            DP_OFF   = (SEG_ACT_LOW != 0);

  logic [PW-1:0]         pre_q, pre_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NDIG-1:0][3:0]  dig_q, dig_d;
  logic [NDIG-1:0]       dpr_q, dpr_d;
  logic [NDIG-1:0]       an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_q, frame_d;

  logic                  tc;
  logic [6:0]            seg_raw;
  logic [NDIG-1:0]       lz_mask;
  logic                  lz_run;
  logic                  blank;
  logic [NDIG-1:0]       an_hot;

  assign tc = (pre_q == PRE_TC);

  // Scan position and shadow capture.
  always_comb begin
    pre_d = pre_q;
    idx_d = idx_q;
    if (bus.en) begin
      if (tc) begin
        pre_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
    dig_d = bus.load ? bus.digits : dig_q;
    dpr_d = bus.load ? bus.dp_in  : dpr_q;
  end

  // lz_mask[i] is set when digit i and every more-significant digit are zero.
  always_comb begin
    lz_run  = 1'b1;
    lz_mask = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      lz_run     = lz_run & (dig_q[i] == 4'd0);
      lz_mask[i] = lz_run;
    end
  end

  assign blank = (BLANK_LZ != 0) && (idx_q != '0) && lz_mask[idx_q];

  bcd_to_seg7 u_dec (
    .bcd_i (dig_q[idx_q]),
    .seg_o (seg_raw)
  );

  // Output next-state: sampled from the current shadow, so a load on the
  // same edge only shows up one cycle later. Prescaler 0 is the anode-off
  // guard slot that hides segment transitions between digits.
  always_comb begin
    an_hot  = NDIG'(1) << idx_q;
    an_d    = an_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
    frame_d = 1'b0;
    if (bus.en) begin
      an_d    = (pre_q == '0) ? AN_OFF : (an_hot ^ AN_OFF);
      seg_d   = (blank ? SEG_BLANK : seg_raw) ^ SEG_OFF;
      dp_d    = dpr_q[idx_q] ^ DP_OFF;
      frame_d = tc && (idx_q == IDX_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q   <= '0;
      idx_q   <= '0;
      dig_q   <= '0;
      dpr_q   <= '0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
      frame_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      dpr_q   <= dpr_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: scoreboard bench for seg7_scan (NDIG=4, SCAN_DIV=4,
// leading-zero blanking, active-low anodes and segments).
module tb_seg7_scan;
  localparam int ND = 4;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_if #(.NDIG(ND)) bus ();

  seg7_scan #(
    .NDIG(ND), .SCAN_DIV(SD), .BLANK_LZ(1), .AN_ACT_LOW(1), .SEG_ACT_LOW(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int             m_pre, m_idx;
  logic [3:0]     m_dig [ND];
  logic [ND-1:0]  m_dpm;
  logic [3:0]     m_an;
  logic [6:0]     m_seg;
  logic           m_dp, m_frame;
  logic [12:0]    sb [$];
  int             n_checks = 0;
  int             n_pass = 0;

  function automatic logic [6:0] ref_dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;  default: return 7'h40;
    endcase
  endfunction

  // Drive one cycle of inputs, advance the reference model at the edge,
  // push the expected registered outputs, and return at the falling edge.
  task automatic cycle(input logic r, input logic e, input logic l,
                       input logic [15:0] d, input logic [3:0] p);
    bit bz;
    rst_n = r; bus.en = e; bus.load = l; bus.digits = d; bus.dp_in = p;
    @(posedge clk);
    if (!r) begin
      m_pre = 0; m_idx = 0; m_dpm = '0;
      for (int j = 0; j < ND; j++) m_dig[j] = 4'd0;
      m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1; m_frame = 1'b0;
    end else begin
      if (e) begin
        bz = (m_idx != 0);
        for (int j = m_idx; j < ND; j++) if (m_dig[j] != 4'd0) bz = 1'b0;
        m_an    = (m_pre == 0) ? 4'hF : ~(4'b0001 << m_idx);
        m_seg   = ~(bz ? 7'h00 : ref_dec(m_dig[m_idx]));
        m_dp    = ~m_dpm[m_idx];
        m_frame = (m_pre == SD - 1) && (m_idx == ND - 1);
        if (m_pre == SD - 1) begin
          m_pre = 0;
          m_idx = (m_idx + 1) % ND;
        end else begin
          m_pre++;
        end
      end else begin
        m_frame = 1'b0;
      end
      if (l) begin
        for (int j = 0; j < ND; j++) m_dig[j] = d[4*j +: 4];
        m_dpm = p;
      end
    end
    sb.push_back({m_an, m_seg, m_dp, m_frame});
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [12:0] ex, gt, mk;
    for (int c = 0; c < 2; c++) begin
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
      ex = sb.pop_front(); gt = {bus.an, bus.seg, bus.dp, bus.frame}; mk = 13'h1FFF;
      n_checks++;
      if ((gt & mk) !== (ex & mk))
        $display("FAIL reset c%0d: got %b required %b (an|seg|dp|frame)", c, gt, ex);
      else n_pass++;
    end
    n_checks++;
    if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.dp !== 1'b1)
      $display("FAIL reset_inactive: got an=%b seg=%h dp=%b required 1111/7f/1", bus.an, bus.seg, bus.dp);
    else n_pass++;
  endtask

  task automatic test_scan_order();
    logic [12:0] ex, gt, mk;
    int frames = 0;
    for (int c = 0; c < 34; c++) begin
      cycle(1'b1, 1'b1, (c == 0), 16'h1234, 4'h0);
      ex = sb.pop_front(); gt = {bus.an, bus.seg, bus.dp, bus.frame};
      mk = (ex[12:9] == 4'hF) ? 13'h1E01 : 13'h1FFF;
      if (c >= 2 && gt[0] === 1'b1) frames++;
      n_checks++;
      if ((gt & mk) !== (ex & mk))
        $display("FAIL scan_order c%0d: got %b required %b", c, gt, ex);
      else n_pass++;
    end
    n_checks++;
    if (frames !== 2) $display("FAIL frame_count: got %0d required 2", frames);
    else n_pass++;
  endtask

  task automatic test_lz();
    logic [12:0] ex, gt, mk;
    for (int c = 0; c < 40; c++) begin
      cycle(1'b1, 1'b1, (c == 0 || c == 20), (c < 20) ? 16'h0070 : 16'h0000, 4'h0);
      ex = sb.pop_front(); gt = {bus.an, bus.seg, bus.dp, bus.frame};
      mk = (ex[12:9] == 4'hF) ? 13'h1E01 : 13'h1FFF;
      n_checks++;
      if ((gt & mk) !== (ex & mk))
        $display("FAIL lz_blank c%0d: got %b required %b", c, gt, ex);
      else n_pass++;
    end
  endtask

  task automatic test_dash_dp();
    logic [12:0] ex, gt, mk;
    for (int c = 0; c < 20; c++) begin
      cycle(1'b1, 1'b1, (c == 0), 16'h00A5, 4'b0010);
      ex = sb.pop_front(); gt = {bus.an, bus.seg, bus.dp, bus.frame};
      mk = (ex[12:9] == 4'hF) ? 13'h1E01 : 13'h1FFF;
      n_checks++;
      if ((gt & mk) !== (ex & mk))
        $display("FAIL dash_dp c%0d: got %b required %b", c, gt, ex);
      else n_pass++;
    end
  endtask

  task automatic test_load_timing();
    logic [12:0] ex, gt, mk;
    int c = 0;
    // Advance until digit 0 is in its first visible cycle.
    while (!(m_idx == 0 && m_pre == 1) && c < 40) begin
      cycle(1'b1, 1'b1, 1'b0, 16'h00A5, 4'b0010);
      void'(sb.pop_front());
      c++;
    end
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 1'b1, (k == 0), 16'h00A9, 4'b0010);
      ex = sb.pop_front(); gt = {bus.an, bus.seg, bus.dp, bus.frame};
      mk = (ex[12:9] == 4'hF) ? 13'h1E01 : 13'h1FFF;
      n_checks++;
      if ((gt & mk) !== (ex & mk))
        $display("FAIL load_timing k%0d: got %b required %b", k, gt, ex);
      else n_pass++;
      if (k < 2) begin
        n_checks++;
        if (bus.seg !== ((k == 0) ? 7'h12 : 7'h10))
          $display("FAIL load_latency k%0d: got seg=%h required %h", k, bus.seg,
                   (k == 0) ? 7'h12 : 7'h10);
        else n_pass++;
      end
    end
  endtask

  task automatic test_en_freeze();
    logic [12:0] ex, gt, mk;
    for (int c = 0; c < 26; c++) begin
      cycle(1'b1, !(c >= 6 && c < 16), 1'b0, 16'h0, 4'h0);
      ex = sb.pop_front(); gt = {bus.an, bus.seg, bus.dp, bus.frame};
      mk = (ex[12:9] == 4'hF) ? 13'h1E01 : 13'h1FFF;
      n_checks++;
      if ((gt & mk) !== (ex & mk))
        $display("FAIL en_freeze c%0d: got %b required %b", c, gt, ex);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] ex, gt, mk;
    int c = 0;
    bit seen = 1'b0;
    while (!(m_idx == 2 && m_pre == 2) && c < 40) begin
      cycle(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
      void'(sb.pop_front());
      c++;
    end
    cycle(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
    void'(sb.pop_front());
    n_checks++;
    if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.frame !== 1'b0)
      $display("FAIL reset_mid: got an=%b seg=%h frame=%b required 1111/7f/0", bus.an, bus.seg, bus.frame);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
      ex = sb.pop_front(); gt = {bus.an, bus.seg, bus.dp, bus.frame};
      mk = (ex[12:9] == 4'hF) ? 13'h1E01 : 13'h1FFF;
      n_checks++;
      if ((gt & mk) !== (ex & mk))
        $display("FAIL reset_restart k%0d: got %b required %b", k, gt, ex);
      else n_pass++;
      if (!seen && bus.an !== 4'hF) begin
        seen = 1'b1;
        n_checks++;
        if (bus.an !== 4'b1110 || bus.seg !== 7'h40)
          $display("FAIL restart_digit0: got an=%b seg=%h required 1110/40", bus.an, bus.seg);
        else n_pass++;
      end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL restart_timeout: got no active anode required digit 0 within 8 cycles");
    end
  endtask

  initial begin
    bus.en = 1'b0; bus.load = 1'b0; bus.digits = '0; bus.dp_in = '0;
    test_reset();
    test_scan_order();
    test_lz();
    test_dash_dp();
    test_load_timing();
    test_en_freeze();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
